// File: rtl/fetch_stage_pkg.sv
// Shared CPU types for the fetch stage: word type, fetch FSM states, PC step.
package fetch_stage_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      REQ    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: icache handshake, hazard/branch controls and IF/ID outputs.
// The slave modport is the fetch stage; the master modport is its environment.
interface fetch_stage_if;
   import fetch_stage_pkg::*;

   logic  ihit;
   word_t iload;
   logic  iREN;
   word_t iaddr;
   logic  stall;
   logic  flush;
   logic  redirect;
   word_t redirect_pc;
   logic  halt;
   word_t instr_out;
   word_t pc4_out;
   logic  valid_out;
   word_t fetch_cnt;

   modport slave (
      input  ihit, iload, stall, flush, redirect, redirect_pc, halt,
      output iREN, iaddr, instr_out, pc4_out, valid_out, fetch_cnt
   );

   modport master (
      output ihit, iload, stall, flush, redirect, redirect_pc, halt,
      input  iREN, iaddr, instr_out, pc4_out, valid_out, fetch_cnt
   );

endinterface

// File: rtl/fetch_stage_ifid_latch.sv
// IF/ID pipeline register: load a fetched word, hold it, or replace it with a bubble.
module ifid_latch
   import fetch_stage_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  load_i,
   input  logic  bubble_i,
   input  word_t instr_i,
   input  word_t pc4_i,
   output word_t instr_o,
   output word_t pc4_o,
   output logic  valid_o
);

   word_t instr_q;
   word_t pc4_q;
   logic  valid_q;

   // Bubble beats load; with neither asserted the register holds.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instr_q <= '0;
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else if (bubble_i) begin
         instr_q <= '0;
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else if (load_i) begin
         instr_q <= instr_i;
         pc4_q   <= pc4_i;
         valid_q <= 1'b1;
      end
   end

   assign instr_o = instr_q;
   assign pc4_o   = pc4_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, pending-redirect register, fetch FSM and IF/ID.
// Optional feature macro: FETCH_PERF_CNT_EN builds the fetch_cnt counter;
// without it fetch_cnt is tied to zero.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter word_t PC_INIT = 32'h0000_0000
) (
   input logic           CLK,
   input logic           nRST,
   fetch_stage_if.slave  bus
);

   fetch_state_t state_q;
   word_t        pc_q;
   word_t        pend_q;
   word_t        pc_plus4;
   word_t        redir_tgt;
   logic         ifid_load;
   logic         ifid_bubble;

   assign pc_plus4  = pc_q + PC_STEP;
   assign redir_tgt = bus.redirect_pc & ~32'h3;

   assign bus.iREN  = nRST && (state_q != HALTED);
   assign bus.iaddr = pc_q;

   // IF/ID control decode: halt/redirect/flush bubble, stall holds, a hit loads, a miss bubbles.
   always_comb begin
      ifid_load   = 1'b0;
      ifid_bubble = 1'b0;
      case (state_q)
         REQ: begin
            if (bus.halt || bus.redirect || bus.flush) begin
               ifid_bubble = 1'b1;
            end else if (!bus.stall) begin
               if (bus.ihit) ifid_load   = 1'b1;
               else          ifid_bubble = 1'b1;
            end
         end
         default: ifid_bubble = 1'b1;
      endcase
   end

   // Fetch FSM with PC and pending target; DRAIN waits out a miss before taking the redirect.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= REQ;
         pc_q    <= PC_INIT;
         pend_q  <= '0;
      end else begin
         case (state_q)
            REQ: begin
               if (bus.halt) begin
                  state_q <= HALTED;
               end else if (bus.redirect) begin
                  if (bus.ihit) begin
                     pc_q <= redir_tgt;
                  end else begin
                     pend_q  <= redir_tgt;
                     state_q <= DRAIN;
                  end
               end else if (bus.ihit && (bus.flush || !bus.stall)) begin
                  pc_q <= pc_plus4;
               end
            end
            DRAIN: begin
               if (bus.halt) begin
                  state_q <= HALTED;
               end else if (bus.ihit) begin
                  // A redirect arriving with the draining hit supersedes the saved target.
                  pc_q    <= bus.redirect ? redir_tgt : pend_q;
                  state_q <= REQ;
               end else if (bus.redirect) begin
                  pend_q <= redir_tgt;
               end
            end
            HALTED: state_q <= HALTED;
            default: state_q <= REQ;
         endcase
      end
   end

   ifid_latch u_ifid (
      .clk      (CLK),
      .rst_n    (nRST),
      .load_i   (ifid_load),
      .bubble_i (ifid_bubble),
      .instr_i  (bus.iload),
      .pc4_i    (pc_plus4),
      .instr_o  (bus.instr_out),
      .pc4_o    (bus.pc4_out),
      .valid_o  (bus.valid_out)
   );

`ifdef FETCH_PERF_CNT_EN
   word_t cnt_q;

   // Count instructions delivered into IF/ID; wraps modulo 2^32.
   always_ff @(posedge CLK) begin
      if (!nRST)          cnt_q <= '0;
      else if (ifid_load) cnt_q <= cnt_q + 32'd1;
   end

   assign bus.fetch_cnt = cnt_q;
`else
   assign bus.fetch_cnt = '0;
`endif

endmodule
